// File: rtl/module_controle_ula.sv
// ALU control unit: accepts an 18-bit instruction on a synchronized enviar edge, reads two
// operands from a synchronous register file, writes the ALU result back, or clears all 16 registers.
module module_controle_ula (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enviar_i,
    input  logic [17:0] instrucao_i,
    output logic [3:0]  ram_addr_o,
    output logic        ram_we_o,
    output logic [15:0] ram_wdata_o,
    input  logic [15:0] ram_rdata_i,
    output logic [2:0]  opcode_o,
    output logic        sinalImm_o,
    output logic [5:0]  Imm_o,
    output logic [15:0] v1ULA_o,
    output logic [15:0] v2ULA_o,
    input  logic [15:0] valorGuardarULA_i,
    output logic [15:0] valorDisplay_o,
    output logic        ocupado_o,
    output logic        pronto_o
);

    typedef enum logic [2:0] {StIdle, StRead1, StRead2, StExec, StWrite, StClr} state_e;

    localparam logic [2:0] OpClear   = 3'b110;
    localparam logic [2:0] OpDisplay = 3'b111;

    state_e      state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [1:0]  fill_q;
    logic        armed_q;
    logic        accept;
    logic [2:0]  op_q;
    logic [3:0]  dest_q, src2_q, addr_q;
    logic        sinal_q;
    logic [5:0]  imm_q;
    logic        we_q, pronto_q;
    logic [15:0] v1_q, v2_q, disp_q;

    // armed_q only rises once the synchronizer has filled and seen enviar low, so a level held
    // through reset release never looks like a fresh press.
    assign accept = sync2_q & ~prev_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            fill_q   <= 2'd0;
            armed_q  <= 1'b0;
            op_q     <= 3'd0;
            dest_q   <= 4'd0;
            src2_q   <= 4'd0;
            addr_q   <= 4'd0;
            sinal_q  <= 1'b0;
            imm_q    <= 6'd0;
            we_q     <= 1'b0;
            pronto_q <= 1'b0;
            v1_q     <= 16'd0;
            v2_q     <= 16'd0;
            disp_q   <= 16'd0;
        end else begin
            sync1_q <= enviar_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!fill_q[1]) begin
                fill_q <= fill_q + 2'd1;
            end else if (!sync2_q) begin
                armed_q <= 1'b1;
            end

            we_q     <= 1'b0;
            pronto_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= instrucao_i[17:15];
                        dest_q  <= instrucao_i[14:11];
                        src2_q  <= instrucao_i[6:3];
                        sinal_q <= instrucao_i[6];
                        imm_q   <= instrucao_i[5:0];
                        if (instrucao_i[17:15] == OpClear) begin
                            state_q <= StClr;
                            addr_q  <= 4'd0;
                            we_q    <= 1'b1;
                            disp_q  <= 16'd0;
                        end else begin
                            state_q <= StRead1;
                            addr_q  <= instrucao_i[10:7];
                        end
                    end
                end
                StRead1: begin
                    addr_q  <= src2_q;
                    state_q <= StRead2;
                end
                StRead2: begin
                    v1_q    <= ram_rdata_i;
                    state_q <= StExec;
                end
                StExec: begin
                    v2_q     <= ram_rdata_i;
                    addr_q   <= dest_q;
                    we_q     <= (op_q != OpDisplay);
                    pronto_q <= 1'b1;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    if (op_q == OpDisplay) begin
                        disp_q <= v1_q;
                    end
                    state_q <= StIdle;
                end
                StClr: begin
                    addr_q   <= addr_q + 4'd1;
                    pronto_q <= (addr_q == 4'd14);
                    if (addr_q == 4'd15) begin
                        state_q <= StIdle;
                    end else begin
                        we_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write data must follow the combinational ALU result in the WRITE cycle itself.
    assign ram_wdata_o    = (state_q == StWrite) ? valorGuardarULA_i : 16'd0;
    assign ram_addr_o     = addr_q;
    assign ram_we_o       = we_q;
    assign opcode_o       = op_q;
    assign sinalImm_o     = sinal_q;
    assign Imm_o          = imm_q;
    assign v1ULA_o        = v1_q;
    assign v2ULA_o        = v2_q;
    assign valorDisplay_o = disp_q;
    assign ocupado_o      = (state_q != StIdle);
    assign pronto_o       = pronto_q;

endmodule

// File: doc/module_controle_ula.md
MODULE_CONTROLE_ULA -- requirements
Module: module_controle_ula

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enviar  input  1  asynchronous active-high submit button.
REQ-005 instrucao  input  18  instruction word with these fields:
- [17:15] opcode
- [14:11] dest
- [10:7] src1
- [6:3] src2
- [6] sinalImm
- [5:0] Imm
REQ-006 ram_addr  output  4  register-file address.
REQ-007 ram_we  output  1  register-file write enable.
REQ-008 ram_wdata  output  16  register-file write data.
REQ-009 ram_rdata  input  16  register-file read data, valid one cycle after ram_addr.
REQ-010 opcode, sinalImm, Imm  output  3/1/6  latched instruction fields driven to the ALU.
REQ-011 v1ULA, v2ULA  output  16  ALU operands.
REQ-012 valorGuardarULA  input  16  combinational ALU result.
REQ-013 valorDisplay  output  16  value shown by DISPLAY.
REQ-014 ocupado  output  1  high whenever state is not IDLE.
REQ-015 pronto  output  1  one-cycle pulse when an instruction completes.

Function
REQ-016 enviar SHALL pass through a 2-flop synchronizer; a command is accepted on the synchronized rising edge, in IDLE only.
REQ-017 Edges of enviar while ocupado=1 SHALL be ignored and not queued.
REQ-018 On acceptance, instrucao SHALL be latched; the outputs opcode, sinalImm and Imm SHALL hold the latched values until the next acceptance.
REQ-019 The FSM states SHALL be IDLE, READ1, READ2, EXEC, WRITE, CLR.
REQ-020 Opcode encoding SHALL be: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
REQ-021 Non-CLEAR flow: accept (cycle 0) -> READ1 (ram_addr=src1) -> READ2 (ram_addr=src2; v1ULA<=ram_rdata) -> EXEC (v2ULA<=ram_rdata) -> WRITE -> IDLE.
REQ-022 WRITE for all opcodes except DISPLAY: ram_we=1 for exactly one cycle, with ram_addr=dest and ram_wdata=valorGuardarULA.
REQ-023 WRITE for DISPLAY: ram_we=0; valorDisplay<=v1ULA.
REQ-024 pronto SHALL pulse in the WRITE cycle; total latency is 4 cycles from acceptance to WRITE.
REQ-025 CLEAR: accept -> CLR for 16 consecutive cycles, with ram_we=1, ram_wdata=0, and ram_addr counting 0..15 by one per cycle.
REQ-026 CLEAR: pronto SHALL pulse in the addr=15 cycle, then the FSM returns to IDLE; the 4-bit counter wraps to 0.
REQ-027 CLEAR SHALL also set valorDisplay to 0.
REQ-028 ram_we SHALL be 0 in every state other than WRITE (non-DISPLAY) and CLR.
REQ-029 dest=src1 or dest=src2 SHALL be legal; operands are captured before the write occurs.
REQ-030 Outside accesses, ram_addr SHALL hold its last value; no outputs may glitch-write.

Reset
REQ-031 rst_n=0 SHALL force, asynchronously:
- state=IDLE
- ram_we=0, pronto=0, ocupado=0
- ram_addr=0, ram_wdata=0, v1ULA=0, v2ULA=0
- opcode=000, sinalImm=0, Imm=0
- valorDisplay=0
- synchronizer flops=0
REQ-032 Reset asserted mid-operation SHALL abort the operation with no further write; a CLEAR in progress leaves the already-written registers zeroed.
REQ-033 A high enviar level held through reset release SHALL NOT be accepted; a fresh rising edge is required.

Verification
REQ-034 ADD:
- Preload R1=5, R2=7; submit ADD dest=3 src1=1 src2=2.
- Expect one write, R3=12, in cycle 4 after acceptance; pronto one pulse.
REQ-035 CLEAR:
- Preload R0..R15 with nonzero values; submit CLEAR.
- Expect 16 writes of 0 at addresses 0..15 in consecutive cycles; ocupado high for 16 cycles; pronto pulse with addr=15.
REQ-036 DISPLAY:
- R4=0x00AB; submit DISPLAY src1=4.
- Expect valorDisplay=0x00AB, no ram_we, pronto pulse.
REQ-037 Busy rejection:
- Submit SUB; toggle enviar again during READ2.
- Expect the second edge ignored; exactly one write; FSM back in IDLE.
REQ-038 Reset mid-CLEAR:
- Assert rst_n=0 while CLEAR is at addr=6.
- Expect R0..R5 (at least) zero, R7..R15 unchanged; all outputs at reset values immediately.
REQ-039 Operand aliasing:
- R2=3; submit ADD dest=2 src1=2 src2=2.
- Expect R2=6.
